// File: rtl/logic_probe_mode_ctrl.sv
// Logic probe mode/threshold controller: debounced mode button, R2R DAC code,
// and comparator sampling blanked while the DAC settles after a threshold change.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SETTLE | DAC settling after reset or a code change; comparators frozen
// ST_RUN    | threshold stable; comparator outputs track the synchronized pins
module logic_probe_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       comp_data_hi,
    input  logic       comp_data_lo,
    output logic [1:0] mode,
    output logic [3:0] dac_value,
    output logic       sample_valid,
    output logic       comp_hi_q,
    output logic       comp_lo_q,
    output logic       comp_fault
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    logic btn_s1, btn_s2;
    logic hi_s1, hi_s2;
    logic lo_s1, lo_s2;

    logic            btn_db;
    logic [DB_W-1:0] db_cnt;
    logic            btn_differs;
    logic            db_flip;
    logic            press;

    state_t          state, state_nxt;
    logic [ST_W-1:0] settle_cnt, settle_nxt;
    logic [1:0]      mode_r, mode_nxt;
    logic [3:0]      dac_r, dac_nxt;

    logic run;
    logic both_high;

    function automatic logic [1:0] advance_mode(input logic [1:0] m);
        case (m)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] dac_code(input logic [1:0] m);
        case (m)
            2'd0:    return 4'd7;
            2'd1:    return 4'd10;
            default: return 4'd12;
        endcase
    endfunction

    // The raw pins are sampled only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            hi_s1  <= 1'b0;
            hi_s2  <= 1'b0;
            lo_s1  <= 1'b0;
            lo_s2  <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            hi_s1  <= comp_data_hi;
            hi_s2  <= hi_s1;
            lo_s1  <= comp_data_lo;
            lo_s2  <= lo_s1;
        end
    end

    assign btn_differs = (btn_s2 != btn_db);
    assign db_flip     = btn_differs && (db_cnt == DB_LAST);
    assign press       = db_flip && !btn_db;

    // Any return to the accepted level throws away the accumulated count.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (!btn_differs) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            btn_db <= btn_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SETTLE;
            settle_cnt <= ST_LOAD;
            mode_r     <= 2'd2;
            dac_r      <= 4'd12;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            mode_r     <= mode_nxt;
            dac_r      <= dac_nxt;
        end
    end

    // A press always restarts the settle window, even on the expiry cycle.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        mode_nxt   = mode_r;
        dac_nxt    = dac_r;

        if (press) begin
            mode_nxt = advance_mode(mode_r);
            dac_nxt  = dac_code(mode_nxt);
        end

        case (state)
            ST_SETTLE: begin
                if (press) begin
                    settle_nxt = ST_LOAD;
                end else if (settle_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    settle_nxt = settle_cnt - ST_W'(1);
                end
            end
            ST_RUN: begin
                if (press) begin
                    state_nxt  = ST_SETTLE;
                    settle_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt  = ST_SETTLE;
                settle_nxt = ST_LOAD;
            end
        endcase
    end

    assign run       = (state == ST_RUN);
    assign both_high = hi_s2 && lo_s2;

    // Both comparators high cannot happen physically; keep the last good levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_hi_q  <= 1'b0;
            comp_lo_q  <= 1'b0;
            comp_fault <= 1'b0;
        end else begin
            comp_fault <= run && both_high;
            if (run && !both_high) begin
                comp_hi_q <= hi_s2;
                comp_lo_q <= lo_s2;
            end
        end
    end

    assign mode         = mode_r;
    assign dac_value    = dac_r;
    assign sample_valid = run;

endmodule

// File: tb/tb_logic_probe_mode_ctrl.sv
// Directed bench for logic_probe_mode_ctrl with short debounce/settle periods.
module tb_logic_probe_mode_ctrl;

    localparam int DEB = 4;
    localparam int SET = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       comp_data_hi = 1'b0;
    logic       comp_data_lo = 1'b0;
    logic [1:0] mode;
    logic [3:0] dac_value;
    logic       sample_valid;
    logic       comp_hi_q;
    logic       comp_lo_q;
    logic       comp_fault;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic hi;
        logic lo;
        logic e_hi;
        logic e_lo;
        logic e_flt;
    } vec_t;

    vec_t vecs [14];

    logic_probe_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .comp_data_hi(comp_data_hi),
        .comp_data_lo(comp_data_lo),
        .mode        (mode),
        .dac_value   (dac_value),
        .sample_valid(sample_valid),
        .comp_hi_q   (comp_hi_q),
        .comp_lo_q   (comp_lo_q),
        .comp_fault  (comp_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [1:0] em, input logic [3:0] ed,
                             input logic esv);
        chk({name, ".mode"}, 4'(mode), 4'(em));
        chk({name, ".dac"}, dac_value, ed);
        chk({name, ".valid"}, 4'(sample_valid), 4'(esv));
    endtask

    task automatic chk_comp(input string name, input logic eh, input logic el, input logic ef);
        chk({name, ".hi_q"}, 4'(comp_hi_q), 4'(eh));
        chk({name, ".lo_q"}, 4'(comp_lo_q), 4'(el));
        chk({name, ".fault"}, 4'(comp_fault), 4'(ef));
    endtask

    // Clean press from idle: mode advances exactly 2+DEB edges after the raw rise.
    task automatic press(input string name, input logic [1:0] old_m, input logic [1:0] new_m,
                         input logic [3:0] new_d);
        btn = 1'b1;
        repeat (5) step();
        chk({name, ".before"}, 4'(mode), 4'(old_m));
        step();
        chk_state(name, new_m, new_d, 1'b0);
        btn = 1'b0;
    endtask

    initial begin
        // {hi, lo, exp hi_q, exp lo_q, exp fault}; outputs lag inputs by two vectors
        vecs = '{
            5'b10_000, 5'b10_000, 5'b00_100, 5'b01_100,
            5'b11_000, 5'b00_010, 5'b00_011, 5'b10_000,
            5'b10_000, 5'b10_100, 5'b01_100, 5'b01_100,
            5'b00_010, 5'b00_010
        };

        // reset and initial settle window
        step();
        step();
        chk_state("reset", 2'd2, 4'd12, 1'b0);
        chk_comp("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < SET; i++) begin
            chk("init_settle", 4'(sample_valid), 4'd0);
            step();
        end
        chk_state("init_run", 2'd2, 4'd12, 1'b1);

        // clean press held 10 cycles: wrap 2 -> 0
        step();
        step();
        btn = 1'b1;
        repeat (5) step();
        chk("clean.before", 4'(mode), 4'd2);
        step();
        chk_state("clean", 2'd0, 4'd7, 1'b0);
        for (int i = 0; i < SET; i++) begin
            if (i == 4) btn = 1'b0;
            chk("clean_settle", 4'(sample_valid), 4'd0);
            step();
        end
        chk_state("clean_run", 2'd0, 4'd7, 1'b1);
        repeat (10) step();
        chk_state("release", 2'd0, 4'd7, 1'b1);

        // bounces shorter than the debounce window are ignored
        repeat (5) begin
            btn = 1'b1;
            repeat (3) step();
            btn = 1'b0;
            repeat (3) step();
        end
        chk_state("bounce", 2'd0, 4'd7, 1'b1);
        press("bounce_hold", 2'd0, 2'd1, 4'd10);
        repeat (16) step();
        chk_state("bounce_idle", 2'd1, 4'd10, 1'b1);

        // second press lands on the settle-expiry cycle and restarts blanking
        btn = 1'b1;
        repeat (4) step();
        btn = 1'b0;
        repeat (2) step();
        chk_state("dp1", 2'd2, 4'd12, 1'b0);
        repeat (2) step();
        btn = 1'b1;
        repeat (5) step();
        chk_state("dp_pre", 2'd2, 4'd12, 1'b0);
        step();
        chk_state("dp2", 2'd0, 4'd7, 1'b0);
        btn = 1'b0;
        for (int i = 0; i < SET - 1; i++) begin
            step();
            chk("dp_settle", 4'(sample_valid), 4'd0);
        end
        step();
        chk_state("dp_run", 2'd0, 4'd7, 1'b1);

        // comparator path in RUN, including the fault hold
        for (int i = 0; i < 14; i++) begin
            comp_data_hi = vecs[i].hi;
            comp_data_lo = vecs[i].lo;
            step();
            chk_comp($sformatf("vec%0d", i), vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_flt);
        end

        // comparator outputs frozen during SETTLE
        comp_data_hi = 1'b1;
        comp_data_lo = 1'b0;
        repeat (4) step();
        chk_comp("pre_freeze", 1'b1, 1'b0, 1'b0);
        press("freeze_press", 2'd0, 2'd1, 4'd10);
        for (int i = 0; i < SET; i++) begin
            comp_data_hi = (i < 6) ? i[0] : 1'b0;
            step();
            chk("frozen_hi", 4'(comp_hi_q), 4'd1);
        end
        step();
        chk_comp("unfrozen", 1'b0, 1'b0, 1'b0);
        chk_state("unfrozen", 2'd1, 4'd10, 1'b1);

        // reset mid-SETTLE with a release still being debounced
        repeat (8) step();
        press("to2", 2'd1, 2'd2, 4'd12);
        repeat (12) step();
        chk("to2_run", 4'(sample_valid), 4'd1);
        comp_data_hi = 1'b1;
        repeat (4) step();
        chk("pre_rst_hi", 4'(comp_hi_q), 4'd1);
        press("wrap", 2'd2, 2'd0, 4'd7);
        repeat (3) step();
        chk("mid_settle", 4'(sample_valid), 4'd0);
        rst = 1'b1;
        step();
        chk_state("mid_rst", 2'd2, 4'd12, 1'b0);
        chk_comp("mid_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < SET; i++) begin
            chk("rst_settle", 4'(sample_valid), 4'd0);
            step();
        end
        chk_state("rst_run", 2'd2, 4'd12, 1'b1);
        chk("rst_run_hi", 4'(comp_hi_q), 4'd0);
        step();
        chk("first_update_hi", 4'(comp_hi_q), 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
